key_schedule_seq: RTL

//  Sequential AES-128 key schedule. Accepts a 128-bit cipher key and produces
//  the 11 round keys (rk0..rk10), one per clock. It reuses the existing

---
 rtl/key_schedule_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/key_schedule_seq.sv
// Sequential AES-128 key schedule: expands one round key per clock into an
// 11-entry round-key file with a registered read port.

module keyexpansion (
    input  logic [127:0] keyInput,
    input  logic [3:0]   keyNum,
    output logic [127:0] keyOutput
);
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc, aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // S-box as multiplicative inverse (x^254, zero maps to zero) plus affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] y, p;
        y = x;
        p = 8'h01;
        for (int i = 0; i < 7; i++) begin
            y = gf_mul(y, y);
            p = gf_mul(p, y);
        end
        return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]}
                 ^ {p[3:0], p[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [4:0] r);
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 1; i < 10; i++)
            if (i < int'(r)) rc = xtime(rc);
        return rc;
    endfunction

    logic [31:0] w0, w1, w2, w3, rot, temp;
    logic [31:0] n0, n1, n2, n3;

    always_comb begin
        {w0, w1, w2, w3} = keyInput;
        rot  = {w3[23:0], w3[31:24]};
        temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
               ^ {rcon({1'b0, keyNum} + 5'd1), 24'h000000};
        n0 = w0 ^ temp;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        keyOutput = {n0, n1, n2, n3};
    end
endmodule

module key_schedule_seq #(
    parameter int KEY_W   = 128,
    parameter int NROUNDS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    output logic             busy,
    output logic             done,
    output logic             keys_valid,
    input  logic [3:0]       rd_idx,
    output logic [KEY_W-1:0] rd_key
);
    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             keys_valid_q, keys_valid_d;
    logic [KEY_W-1:0] rd_key_q, rd_key_d;
    logic [KEY_W-1:0] rk_q [0:NROUNDS];
    logic [KEY_W-1:0] rk_d [0:NROUNDS];
    logic [KEY_W-1:0] exp_in, exp_out;

    keyexpansion u_keyexpansion (
        .keyInput  (exp_in),
        .keyNum    (cnt_q - 4'd1),
        .keyOutput (exp_out)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        keys_valid_d = keys_valid_q;
        rk_d         = rk_q;
        rd_key_d     = '0;
        exp_in       = '0;

        // Previous round key feeds the expander; cnt_q is 1..NROUNDS while expanding
        for (int i = 0; i < NROUNDS; i++)
            if (cnt_q == 4'(i + 1)) exp_in = rk_q[i];

        case (state_q)
            EXPAND: begin
                for (int i = 1; i <= NROUNDS; i++)
                    if (cnt_q == 4'(i)) rk_d[i] = exp_out;
                if (cnt_q == 4'(NROUNDS)) begin
                    state_d      = READY;
                    done_d       = 1'b1;
                    keys_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                if (key_valid) begin
                    rk_d[0]      = key_in;
                    cnt_d        = 4'd1;
                    keys_valid_d = 1'b0;
                    state_d      = EXPAND;
                end
            end
        endcase

        // Read port samples the current file, so a same-edge write returns the old key
        for (int i = 0; i <= NROUNDS; i++)
            if (rd_idx == 4'(i)) rd_key_d = rk_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            done_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            rd_key_q     <= '0;
            for (int i = 0; i <= NROUNDS; i++) rk_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            keys_valid_q <= keys_valid_d;
            rd_key_q     <= rd_key_d;
            rk_q         <= rk_d;
        end
    end

    assign busy       = (state_q == EXPAND);
    assign key_ready  = (state_q != EXPAND);
    assign done       = done_q;
    assign keys_valid = keys_valid_q;
    assign rd_key     = rd_key_q;
endmodule
